register_file_2r1w: RTL and testbench
=====================================

Name: register_file_2r1w

Overview:
Parametrised two-read, one-write register file for the datapath. It replaces the fixed 32-way read multiplexing with storage and N-way read selection in one block, and adds write-to-read bypass, an optional hardwired zero register and an optional registered-read mode. It sits between decode (read addresses) and write-back (write port).

Parameters:
DATA_WIDTH, 32, width of each register and of all data ports
NUM_REGS, 32, number of implemented registers (2..2**ADDR_WIDTH)
ADDR_WIDTH, 5, width of all address ports
ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes; 0 = register 0 is ordinary storage
BYPASS, 1, 1 = a read of the register being written this cycle returns Write_Data
READ_REG, 0, 0 = combinational reads (latency 0); 1 = registered reads (latency 1)

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
Reg_Write  input  1  write enable
Write_Register  input  ADDR_WIDTH  write address
Write_Data  input  DATA_WIDTH  write data
Read_Register_1  input  ADDR_WIDTH  read port 1 address
Read_Register_2  input  ADDR_WIDTH  read port 2 address
Read_Data_1  output  DATA_WIDTH  read port 1 data
Read_Data_2  output  DATA_WIDTH  read port 2 data

Behaviour:
- One clock; reset is synchronous and active-high: sampled only on the rising edge of clk.
- Reset: at the first clk edge with reset=1, all NUM_REGS registers are cleared to 0. With READ_REG=1, both Read_Data outputs also become 0 at that edge.
- Reset has priority: a write presented in a reset cycle is discarded.
- Reset is allowed mid-stream. There are no other state elements and no pending state survives it.
- Address validity: an address is writable if it is < NUM_REGS and not (ZERO_REG=1 and address=0).
- Write: at the clk edge with reset=0, Reg_Write=1 and a writable Write_Register, Write_Data is stored. Otherwise no register changes.
- Read value rule, per port, independently:
  - address >= NUM_REGS: value = 0.
  - ZERO_REG=1 and address=0: value = 0, even if a write to 0 is presented.
  - BYPASS=1, reset=0, Reg_Write=1 and address = Write_Register (writable): value = Write_Data.
  - otherwise: value = stored register content.
- READ_REG=0: Read_Data_n is the read value, purely combinational from the current inputs and storage. Latency is 0.
- READ_REG=0, BYPASS=0: a read of the register being written shows the old value until the edge, then the new value.
- READ_REG=1: Read_Data_n takes the read value at each clk edge with reset=0 and holds between edges. Latency is 1 cycle.
- READ_REG=1, BYPASS=1: the captured value equals the post-write content.
- READ_REG=1, BYPASS=0: the captured value is the pre-write content.
- Both ports may address the same register, and either may equal Write_Register. Each port follows the rule above with no port priority.
- There is no arithmetic. All data is passed unmodified at DATA_WIDTH.
- Elaboration check: NUM_REGS must be <= 2**ADDR_WIDTH and >= 2. Any other value is a configuration error.

Test Plan:
- Defaults, reset=1 for one edge, then reset=0: read addresses 0..31 on both ports -> all Read_Data = 0x00000000.
- Write 0xDEADBEEF to reg 5, then 0x12345678 to reg 31; read R1=5, R2=31 -> 0xDEADBEEF / 0x12345678, with no cross-talk to regs 4, 6 or 30.
- ZERO_REG=1: write 0xFFFFFFFF to reg 0 with R1=0 in the same and the next cycle -> Read_Data_1 = 0 both cycles. ZERO_REG=0: the next-cycle read returns 0xFFFFFFFF.
- Bypass, READ_REG=0, reg 7 holding 0x1: write 0xA5A5A5A5 to reg 7 with R1=R2=7 -> both ports show 0xA5A5A5A5 in the same cycle. With BYPASS=0 they show 0x1 until the edge, then 0xA5A5A5A5.
- READ_REG=1: R1=3 (holding 0x55) at edge k -> Read_Data_1 = 0x55 from edge k. A write of 0x66 to reg 3 in the same cycle -> 0x66 with BYPASS=1, 0x55 with BYPASS=0.
- NUM_REGS=24, ADDR_WIDTH=5: write 0x77 to reg 27, read R1=27 -> 0. Then assert reset with Reg_Write=1 to reg 2 (0x99) -> reg 2 = 0 after the edge, and Read_Data = 0 when READ_REG=1.

Source files
------------

// File: rtl/register_file_2r1w.sv
// register_file_2r1w: parametrised 2-read 1-write register file with bypass, zero register and optional registered reads
module register_file_2r1w #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1,
  parameter int READ_REG   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Reg_Write,
  input  logic [ADDR_WIDTH-1:0] Write_Register,
  input  logic [DATA_WIDTH-1:0] Write_Data,
  input  logic [ADDR_WIDTH-1:0] Read_Register_1,
  input  logic [ADDR_WIDTH-1:0] Read_Register_2,
  output logic [DATA_WIDTH-1:0] Read_Data_1,
  output logic [DATA_WIDTH-1:0] Read_Data_2
);
  if (NUM_REGS < 2 || NUM_REGS > 2 ** ADDR_WIDTH) begin : g_bad_cfg
    $error("register_file_2r1w: NUM_REGS out of range");
  end
  localparam logic [ADDR_WIDTH:0] NR = NUM_REGS[ADDR_WIDTH:0];
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] rv1, rv2;
  always_comb begin
    wr_en = !reset && Reg_Write && ({1'b0, Write_Register} < NR) && !(ZERO_REG != 0 && Write_Register == '0);
    rv1 = ({1'b0, Read_Register_1} >= NR || (ZERO_REG != 0 && Read_Register_1 == '0)) ? '0 :
          (BYPASS != 0 && wr_en && Read_Register_1 == Write_Register) ? Write_Data : regs_q[Read_Register_1];
    rv2 = ({1'b0, Read_Register_2} >= NR || (ZERO_REG != 0 && Read_Register_2 == '0)) ? '0 :
          (BYPASS != 0 && wr_en && Read_Register_2 == Write_Register) ? Write_Data : regs_q[Read_Register_2];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[Write_Register] <= Write_Data;
    end
  end
  if (READ_REG != 0) begin : g_rd_reg
    logic [DATA_WIDTH-1:0] rd1_q, rd2_q;
    always_ff @(posedge clk) begin
      rd1_q <= reset ? '0 : rv1;
      rd2_q <= reset ? '0 : rv2;
    end
    assign Read_Data_1 = rd1_q;
    assign Read_Data_2 = rd2_q;
  end else begin : g_rd_comb
    assign Read_Data_1 = rv1;
    assign Read_Data_2 = rv2;
  end
endmodule

// File: tb/tb_register_file_2r1w.sv
// tb_register_file_2r1w: randomized self-checking bench over three register file configurations
module tb_register_file_2r1w;
  logic        clk = 0;
  logic        rst, we;
  logic [4:0]  wa, ra1, ra2;
  logic [31:0] wd;
  logic [31:0] rd1 [3];
  logic [31:0] rd2 [3];
  int          n_chk = 0, n_fail = 0;
  int          nr [3] = '{32, 24, 32};
  bit          zr [3] = '{1, 0, 1};
  bit          bp [3] = '{1, 0, 1};
  bit          rr [3] = '{0, 1, 1};
  logic [31:0] mem [3][32];

  always #5 clk = ~clk;

  register_file_2r1w #(.DATA_WIDTH(32), .NUM_REGS(32), .ADDR_WIDTH(5), .ZERO_REG(1), .BYPASS(1), .READ_REG(0)) u_a (
    .clk(clk), .reset(rst), .Reg_Write(we), .Write_Register(wa), .Write_Data(wd),
    .Read_Register_1(ra1), .Read_Register_2(ra2), .Read_Data_1(rd1[0]), .Read_Data_2(rd2[0]));
  register_file_2r1w #(.DATA_WIDTH(32), .NUM_REGS(24), .ADDR_WIDTH(5), .ZERO_REG(0), .BYPASS(0), .READ_REG(1)) u_b (
    .clk(clk), .reset(rst), .Reg_Write(we), .Write_Register(wa), .Write_Data(wd),
    .Read_Register_1(ra1), .Read_Register_2(ra2), .Read_Data_1(rd1[1]), .Read_Data_2(rd2[1]));
  register_file_2r1w #(.DATA_WIDTH(32), .NUM_REGS(32), .ADDR_WIDTH(5), .ZERO_REG(1), .BYPASS(1), .READ_REG(1)) u_c (
    .clk(clk), .reset(rst), .Reg_Write(we), .Write_Register(wa), .Write_Data(wd),
    .Read_Register_1(ra1), .Read_Register_2(ra2), .Read_Data_1(rd1[2]), .Read_Data_2(rd2[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit writable(int c, logic [4:0] a);
    return int'(a) < nr[c] && !(zr[c] && a == 0);
  endfunction

  function automatic logic [31:0] model_rd(int c, logic [4:0] a);
    if (int'(a) >= nr[c] || (zr[c] && a == 0)) return 32'h0;
    if (bp[c] && !rst && we && a == wa && writable(c, wa)) return wd;
    return mem[c][a];
  endfunction

  task automatic cyc(input bit ck, input logic r, input logic w, input logic [4:0] wa_, input logic [31:0] wd_,
                     input logic [4:0] a1, input logic [4:0] a2);
    logic [31:0] e1 [3];
    logic [31:0] e2 [3];
    @(negedge clk);
    rst = r; we = w; wa = wa_; wd = wd_; ra1 = a1; ra2 = a2;
    #1;
    for (int c = 0; c < 3; c++) begin
      e1[c] = (rr[c] && r) ? 32'h0 : model_rd(c, a1);
      e2[c] = (rr[c] && r) ? 32'h0 : model_rd(c, a2);
      if (ck && !rr[c]) begin
        chk($sformatf("cfg%0d_rd1_a%0d", c, a1), rd1[c], e1[c]);
        chk($sformatf("cfg%0d_rd2_a%0d", c, a2), rd2[c], e2[c]);
      end
    end
    @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      if (r) for (int i = 0; i < 32; i++) mem[c][i] = 32'h0;
      else if (w && writable(c, wa_)) mem[c][wa_] = wd_;
    end
    #1;
    for (int c = 0; c < 3; c++) begin
      if (ck && rr[c]) begin
        chk($sformatf("cfg%0d_q1_a%0d", c, a1), rd1[c], e1[c]);
        chk($sformatf("cfg%0d_q2_a%0d", c, a2), rd2[c], e2[c]);
      end
    end
  endtask

  initial begin
    logic [4:0] w_a, a1, a2;
    cyc(0, 1, 0, 0, 0, 0, 0);
    for (int a = 0; a < 32; a++) cyc(1, 0, 0, 0, 0, 5'(a), 5'(31 - a));
    cyc(1, 0, 1, 5, 32'hDEADBEEF, 5, 31);
    cyc(1, 0, 1, 31, 32'h12345678, 5, 31);
    cyc(1, 0, 0, 0, 0, 5, 31);
    cyc(1, 0, 0, 0, 0, 4, 6);
    cyc(1, 0, 0, 0, 0, 30, 31);
    cyc(1, 0, 1, 0, 32'hFFFFFFFF, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 7, 32'h1, 7, 7);
    cyc(1, 0, 1, 7, 32'hA5A5A5A5, 7, 7);
    cyc(1, 0, 0, 0, 0, 7, 7);
    cyc(1, 0, 1, 3, 32'h55, 3, 3);
    cyc(1, 0, 0, 0, 0, 3, 3);
    cyc(1, 0, 1, 3, 32'h66, 3, 3);
    cyc(1, 0, 0, 0, 0, 3, 3);
    cyc(1, 0, 1, 27, 32'h77, 27, 27);
    cyc(1, 0, 0, 0, 0, 27, 27);
    cyc(1, 0, 1, 2, 32'h22, 2, 27);
    cyc(1, 1, 1, 2, 32'h99, 2, 27);
    cyc(1, 0, 0, 0, 0, 2, 27);
    for (int n = 0; n < 600; n++) begin
      w_a = 5'($urandom_range(31));
      a1 = ($urandom_range(3) == 0) ? w_a : 5'($urandom_range(31));
      a2 = ($urandom_range(3) == 0) ? w_a : 5'($urandom_range(31));
      cyc(1, $urandom_range(49) == 0, 1'($urandom_range(1)), w_a, $urandom, a1, a2);
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
